// File: rtl/sadd_rr_arbiter.sv
// sadd_rr_arbiter: round-robin shared signed adder with overflow flag and optional saturation
module sadd_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4,
  parameter bit SATURATE = 1'b0,
  parameter int IDW = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_left,
  input  logic [N_REQ*WIDTH-1:0] req_right,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WIDTH-1:0]       resp_out,
  output logic [IDW-1:0]         resp_id,
  output logic                   resp_ovf
);
  logic [IDW-1:0] ptr, win, nxt;
  logic found, can_accept, accept, ovf;
  logic [WIDTH-1:0] l, r, sum, res;
  // scan downwards from ptr+N_REQ-1 so the requester closest to ptr is assigned last and wins
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = N_REQ-1; k >= 0; k--)
      if (req_valid[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        win = IDW'((int'(ptr) + k) % N_REQ);
      end
  end
  assign can_accept = !resp_valid || resp_ready;
  assign accept = found && can_accept;
  assign req_ready = (reset_n && accept) ? N_REQ'(1) << win : '0;
  assign l = req_left[win*WIDTH +: WIDTH];
  assign r = req_right[win*WIDTH +: WIDTH];
  assign sum = l + r;
  assign ovf = (l[WIDTH-1] == r[WIDTH-1]) && (sum[WIDTH-1] != l[WIDTH-1]);
  assign res = (SATURATE && ovf) ? {l[WIDTH-1], {(WIDTH-1){!l[WIDTH-1]}}} : sum;
  assign nxt = (win == IDW'(N_REQ-1)) ? '0 : win + 1'b1;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_out <= '0;
      resp_id <= '0;
      resp_ovf <= 1'b0;
      ptr <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_out <= res;
      resp_id <= win;
      resp_ovf <= ovf;
      ptr <= nxt;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end
endmodule
